// File: rtl/cache_mem_narrow_bridge_pkg.sv
// Memory message types shared by the cache and the narrow-memory bridge.
// Field order is MSB first; widths match the 16B line port and the 4B word port.
package cache_mem_narrow_bridge_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    // len 0 means a full-width access on both the line and the word ports
    localparam logic [3:0] MEM_LEN_FULL   = 4'd0;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    function automatic logic [2:0] beats_for_len(input logic [3:0] len);
        return (len == MEM_LEN_FULL) ? 3'd4 : 3'd1;
    endfunction

endpackage

// File: rtl/cache_mem_narrow_bridge_dpath.sv
// Bridge datapath: latched line request, per-beat word request mux, 128-bit response assembly.
// Purely registered state; beat selection and word writes are steered by the control in the top.
module cache_MemBridgeDpath
    import cache_mem_narrow_bridge_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  mem_req_16B_t  i_req,
    input  logic [1:0]    i_beat_idx,
    input  logic          i_four_beat,
    output mem_req_4B_t   o_beat,
    input  logic          i_asm_wr,
    input  logic [1:0]    i_asm_idx,
    input  logic [31:0]   i_asm_dat,
    input  logic          i_asm_clr,
    output mem_resp_16B_t o_line_resp
);

    mem_req_16B_t r_req;
    logic [127:0] r_asm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req <= '0;
        end else if (i_load) begin
            r_req <= i_req;
        end
    end

    // Only reads carry data back; WRITE and INIT responses just count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm <= '0;
        end else if (i_asm_clr) begin
            r_asm <= '0;
        end else if (i_asm_wr && (r_req.msg_type == MEM_TYPE_READ)) begin
            r_asm[{i_asm_idx, 5'd0} +: 32] <= i_asm_dat;
        end
    end

    always_comb begin
        o_beat          = '0;
        o_beat.msg_type = r_req.msg_type;
        o_beat.opaque   = r_req.opaque;
        o_beat.addr     = i_four_beat ? {r_req.addr[31:4], i_beat_idx, 2'b00} : r_req.addr;
        o_beat.len      = i_four_beat ? 2'd0 : r_req.len[1:0];
        o_beat.data     = r_req.data[{i_beat_idx, 5'd0} +: 32];
    end

    always_comb begin
        o_line_resp          = '0;
        o_line_resp.msg_type = r_req.msg_type;
        o_line_resp.opaque   = r_req.opaque;
        o_line_resp.test     = 2'd0;
        o_line_resp.len      = r_req.len;
        o_line_resp.data     = r_asm;
    end

endmodule

// File: rtl/cache_mem_narrow_bridge.sv
// Splits each 16B cache line request into 1 or 4 pipelined 4B memory beats and reassembles one 16B response.
// First beat one cycle after accept; mem rdy low holds the beat, cache resp rdy low holds the line response.
module cache_mem_narrow_bridge
    import cache_mem_narrow_bridge_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  cache2mem_reqstream_msg,
    input  logic          cache2mem_reqstream_val,
    output logic          cache2mem_reqstream_rdy,
    output mem_resp_16B_t cache2mem_respstream_msg,
    output logic          cache2mem_respstream_val,
    input  logic          cache2mem_respstream_rdy,
    output mem_req_4B_t   mem_reqstream_msg,
    output logic          mem_reqstream_val,
    input  logic          mem_reqstream_rdy,
    input  mem_resp_4B_t  mem_respstream_msg,
    input  logic          mem_respstream_val,
    output logic          mem_respstream_rdy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_issue_cnt;
    logic [2:0]    r_resp_cnt;
    logic [2:0]    r_nbeats;
    logic [2:0]    w_issue_cnt_nxt;
    logic [2:0]    w_resp_cnt_nxt;
    logic          w_req_fire;
    logic          w_beat_fire;
    logic          w_resp_fire;
    logic          w_asm_clr;
    mem_req_4B_t   w_beat;
    mem_resp_16B_t w_line_resp;
    logic          w_unused_resp;

    assign cache2mem_reqstream_rdy  = (r_state == ST_IDLE);
    assign mem_reqstream_val        = (r_state == ST_ISSUE);
    assign cache2mem_respstream_val = (r_state == ST_RESP);
    assign mem_respstream_rdy       = ((r_state == ST_ISSUE) || (r_state == ST_WAIT))
                                      && (r_resp_cnt < r_nbeats);

    assign w_req_fire  = cache2mem_reqstream_val & cache2mem_reqstream_rdy;
    assign w_beat_fire = mem_reqstream_val & mem_reqstream_rdy;
    assign w_resp_fire = mem_respstream_val & mem_respstream_rdy;

    // Issue and response counters advance independently so beats overlap responses.
    assign w_issue_cnt_nxt = r_issue_cnt + {2'b00, w_beat_fire};
    assign w_resp_cnt_nxt  = r_resp_cnt + {2'b00, w_resp_fire};

    assign w_unused_resp = ^{mem_respstream_msg.msg_type, mem_respstream_msg.opaque,
                             mem_respstream_msg.test, mem_respstream_msg.len};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= '0;
            r_resp_cnt  <= '0;
            r_nbeats    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_fire) begin
                r_issue_cnt <= '0;
                r_resp_cnt  <= '0;
                r_nbeats    <= beats_for_len(cache2mem_reqstream_msg.len);
            end else begin
                r_issue_cnt <= w_issue_cnt_nxt;
                r_resp_cnt  <= w_resp_cnt_nxt;
            end
        end
    end

    // Completion looks at next-cycle counts so the line response follows the last word directly.
    always_comb begin
        w_state_nxt = r_state;
        w_asm_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cache2mem_reqstream_val) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_issue_cnt_nxt == r_nbeats) begin
                    w_state_nxt = (w_resp_cnt_nxt == r_nbeats) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_resp_cnt_nxt == r_nbeats) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cache2mem_respstream_rdy) begin
                    w_state_nxt = ST_IDLE;
                    w_asm_clr   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    cache_MemBridgeDpath u_dpath (
        .clk         (clk),
        .rst_n       (reset),
        .i_load      (w_req_fire),
        .i_req       (cache2mem_reqstream_msg),
        .i_beat_idx  (r_issue_cnt[1:0]),
        .i_four_beat (r_nbeats[2]),
        .o_beat      (w_beat),
        .i_asm_wr    (w_resp_fire),
        .i_asm_idx   (r_resp_cnt[1:0]),
        .i_asm_dat   (mem_respstream_msg.data),
        .i_asm_clr   (w_asm_clr),
        .o_line_resp (w_line_resp)
    );

    assign mem_reqstream_msg        = mem_reqstream_val ? w_beat : '0;
    assign cache2mem_respstream_msg = cache2mem_respstream_val ? w_line_resp : '0;

`ifndef SYNTHESIS
    function automatic string line_trace();
        case (r_state)
            ST_IDLE:  return "I ";
            ST_ISSUE: return "IS";
            ST_WAIT:  return "W ";
            ST_RESP:  return "R ";
            default:  return "? ";
        endcase
    endfunction
`endif

endmodule

// File: tb/tb_cache_mem_narrow_bridge.sv
// Directed bench for cache_mem_narrow_bridge with a 1-cycle in-order word memory model.
module tb_cache_mem_narrow_bridge;
    import cache_mem_narrow_bridge_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    mem_req_16B_t  cache2mem_reqstream_msg;
    logic          cache2mem_reqstream_val;
    logic          cache2mem_reqstream_rdy;
    mem_resp_16B_t cache2mem_respstream_msg;
    logic          cache2mem_respstream_val;
    logic          cache2mem_respstream_rdy;
    mem_req_4B_t   mem_reqstream_msg;
    logic          mem_reqstream_val;
    logic          mem_reqstream_rdy;
    mem_resp_4B_t  mem_respstream_msg = '0;
    logic          mem_respstream_val = 1'b0;
    logic          mem_respstream_rdy;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   rd_words [4];
    mem_req_4B_t   beat_log [$];
    mem_resp_4B_t  pend_q [$];

    always #5 clk = ~clk;

    cache_mem_narrow_bridge dut (
        .clk                      (clk),
        .reset                    (reset),
        .cache2mem_reqstream_msg  (cache2mem_reqstream_msg),
        .cache2mem_reqstream_val  (cache2mem_reqstream_val),
        .cache2mem_reqstream_rdy  (cache2mem_reqstream_rdy),
        .cache2mem_respstream_msg (cache2mem_respstream_msg),
        .cache2mem_respstream_val (cache2mem_respstream_val),
        .cache2mem_respstream_rdy (cache2mem_respstream_rdy),
        .mem_reqstream_msg        (mem_reqstream_msg),
        .mem_reqstream_val        (mem_reqstream_val),
        .mem_reqstream_rdy        (mem_reqstream_rdy),
        .mem_respstream_msg       (mem_respstream_msg),
        .mem_respstream_val       (mem_respstream_val),
        .mem_respstream_rdy       (mem_respstream_rdy)
    );

    // Word memory: answers each accepted beat on the next cycle; writes return junk data.
    always @(posedge clk) begin : mem_model
        logic         fire_req;
        logic         fire_resp;
        mem_req_4B_t  req;
        mem_resp_4B_t rsp;
        fire_req  = mem_reqstream_val && mem_reqstream_rdy;
        fire_resp = mem_respstream_val && mem_respstream_rdy;
        req       = mem_reqstream_msg;
        #1;
        if (!reset) begin
            pend_q.delete();
        end else begin
            if (fire_resp) void'(pend_q.pop_front());
            if (fire_req) begin
                beat_log.push_back(req);
                rsp.msg_type = req.msg_type;
                rsp.opaque   = req.opaque;
                rsp.test     = 2'd0;
                rsp.len      = req.len;
                rsp.data     = (req.msg_type == MEM_TYPE_READ) ? rd_words[req.addr[3:2]]
                                                               : {16'hBAD0, req.addr[15:0]};
                pend_q.push_back(rsp);
            end
        end
        mem_respstream_val = (pend_q.size() != 0);
        if (pend_q.size() != 0) mem_respstream_msg = pend_q[0];
        else                    mem_respstream_msg = '0;
    end

    function automatic mem_req_16B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                            input logic [31:0] a, input logic [3:0] l,
                                            input logic [127:0] d);
        mem_req_16B_t r;
        r.msg_type = t; r.opaque = op; r.addr = a; r.len = l; r.data = d;
        return r;
    endfunction

    // Called at a negedge while the bridge is idle; returns at the negedge of cycle T+1.
    task automatic send_req(input mem_req_16B_t m);
        cache2mem_reqstream_msg = m;
        cache2mem_reqstream_val = 1'b1;
        @(negedge clk);
        cache2mem_reqstream_val = 1'b0;
        cache2mem_reqstream_msg = '0;
    endtask

    task automatic wait_resp(input int limit, output int lat);
        lat = 1;
        while (!cache2mem_respstream_val && lat < limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (cache2mem_reqstream_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_req_rdy got %b want 1", cache2mem_reqstream_rdy); end
        n_cmp++; if (mem_reqstream_val !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req_val got %b want 0", mem_reqstream_val); end
        n_cmp++; if (mem_respstream_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_mem_resp_rdy got %b want 0", mem_respstream_rdy); end
        n_cmp++; if (cache2mem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL rst_resp_val got %b want 0", cache2mem_respstream_val); end
        n_cmp++; if (mem_reqstream_msg !== '0) begin n_bad++; $display("FAIL rst_mem_req_msg got %h want 0", mem_reqstream_msg); end
        n_cmp++; if (cache2mem_respstream_msg !== '0) begin n_bad++; $display("FAIL rst_resp_msg got %h want 0", cache2mem_respstream_msg); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (cache2mem_reqstream_rdy !== 1'b1 || mem_reqstream_val !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle got rdy=%b val=%b want 1/0", cache2mem_reqstream_rdy, mem_reqstream_val); end
    endtask

    task automatic test_full_read();
        int lat;
        beat_log.delete();
        rd_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send_req(mk_req(MEM_TYPE_READ, 8'h5A, 32'h00001000, 4'd0, 128'h0));
        n_cmp++; if (mem_reqstream_val !== 1'b1 || mem_reqstream_msg.addr !== 32'h00001000) begin n_bad++; $display("FAIL rd_first_beat got val=%b addr=%h want 1/00001000", mem_reqstream_val, mem_reqstream_msg.addr); end
        wait_resp(20, lat);
        n_cmp++; if (cache2mem_respstream_val !== 1'b1 || lat != 6) begin n_bad++; $display("FAIL rd_latency got val=%b lat=%0d want 1/6", cache2mem_respstream_val, lat); end
        n_cmp++; if (cache2mem_respstream_msg.data !== 128'h44444444_33333333_22222222_11111111) begin n_bad++; $display("FAIL rd_data got %h want 44444444333333332222222211111111", cache2mem_respstream_msg.data); end
        n_cmp++; if (cache2mem_respstream_msg.opaque !== 8'h5A || cache2mem_respstream_msg.msg_type !== MEM_TYPE_READ || cache2mem_respstream_msg.len !== 4'd0) begin n_bad++; $display("FAIL rd_hdr got op=%h type=%0d len=%0d want 5a/0/0", cache2mem_respstream_msg.opaque, cache2mem_respstream_msg.msg_type, cache2mem_respstream_msg.len); end
        n_cmp++; if (beat_log.size() != 4) begin n_bad++; $display("FAIL rd_beat_count got %0d want 4", beat_log.size()); end
        for (int k = 0; k < 4 && k < beat_log.size(); k++) begin
            n_cmp++; if (beat_log[k].addr !== 32'h00001000 + 32'(4 * k) || beat_log[k].len !== 2'd0 || beat_log[k].msg_type !== MEM_TYPE_READ) begin n_bad++; $display("FAIL rd_beat%0d got addr=%h len=%0d want %h/0", k, beat_log[k].addr, beat_log[k].len, 32'h00001000 + 32'(4 * k)); end
        end
        @(negedge clk);
        n_cmp++; if (cache2mem_respstream_val !== 1'b0 || cache2mem_reqstream_rdy !== 1'b1) begin n_bad++; $display("FAIL rd_back_idle got val=%b rdy=%b want 0/1", cache2mem_respstream_val, cache2mem_reqstream_rdy); end
    endtask

    task automatic test_single_word();
        int lat;
        beat_log.delete();
        rd_words[1] = 32'hCAFEF00D;
        send_req(mk_req(MEM_TYPE_READ, 8'h33, 32'h00000104, 4'd4, 128'h0));
        wait_resp(20, lat);
        n_cmp++; if (cache2mem_respstream_val !== 1'b1 || lat != 3) begin n_bad++; $display("FAIL sw_latency got val=%b lat=%0d want 1/3", cache2mem_respstream_val, lat); end
        n_cmp++; if (cache2mem_respstream_msg.data !== 128'h00000000_00000000_00000000_CAFEF00D) begin n_bad++; $display("FAIL sw_data got %h want 000000000000000000000000cafef00d", cache2mem_respstream_msg.data); end
        n_cmp++; if (cache2mem_respstream_msg.len !== 4'd4 || cache2mem_respstream_msg.opaque !== 8'h33) begin n_bad++; $display("FAIL sw_hdr got len=%0d op=%h want 4/33", cache2mem_respstream_msg.len, cache2mem_respstream_msg.opaque); end
        n_cmp++; if (beat_log.size() != 1) begin n_bad++; $display("FAIL sw_beat_count got %0d want 1", beat_log.size()); end
        else begin
            n_cmp++; if (beat_log[0].addr !== 32'h00000104 || beat_log[0].len !== 2'd0) begin n_bad++; $display("FAIL sw_beat got addr=%h len=%0d want 00000104/0", beat_log[0].addr, beat_log[0].len); end
        end
        @(negedge clk);
    endtask

    task automatic test_full_write();
        int lat;
        logic [31:0] exp_w [4];
        exp_w = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
        beat_log.delete();
        send_req(mk_req(MEM_TYPE_WRITE, 8'h21, 32'h00002040, 4'd0,
                        128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA));
        wait_resp(20, lat);
        n_cmp++; if (cache2mem_respstream_val !== 1'b1 || lat != 6) begin n_bad++; $display("FAIL wr_latency got val=%b lat=%0d want 1/6", cache2mem_respstream_val, lat); end
        n_cmp++; if (cache2mem_respstream_msg.data !== 128'h0 || cache2mem_respstream_msg.msg_type !== MEM_TYPE_WRITE || cache2mem_respstream_msg.opaque !== 8'h21) begin n_bad++; $display("FAIL wr_resp got data=%h type=%0d op=%h want 0/1/21", cache2mem_respstream_msg.data, cache2mem_respstream_msg.msg_type, cache2mem_respstream_msg.opaque); end
        n_cmp++; if (beat_log.size() != 4) begin n_bad++; $display("FAIL wr_beat_count got %0d want 4", beat_log.size()); end
        for (int k = 0; k < 4 && k < beat_log.size(); k++) begin
            n_cmp++; if (beat_log[k].data !== exp_w[k] || beat_log[k].addr !== 32'h00002040 + 32'(4 * k) || beat_log[k].msg_type !== MEM_TYPE_WRITE) begin n_bad++; $display("FAIL wr_beat%0d got addr=%h data=%h want %h/%h", k, beat_log[k].addr, beat_log[k].data, 32'h00002040 + 32'(4 * k), exp_w[k]); end
        end
        @(negedge clk);
    endtask

    task automatic test_init_word();
        int lat;
        beat_log.delete();
        send_req(mk_req(MEM_TYPE_INIT, 8'h9C, 32'h00000208, 4'd2, 128'h12345678));
        wait_resp(20, lat);
        n_cmp++; if (cache2mem_respstream_val !== 1'b1 || lat != 3) begin n_bad++; $display("FAIL init_latency got val=%b lat=%0d want 1/3", cache2mem_respstream_val, lat); end
        n_cmp++; if (cache2mem_respstream_msg.data !== 128'h0 || cache2mem_respstream_msg.msg_type !== MEM_TYPE_INIT || cache2mem_respstream_msg.len !== 4'd2) begin n_bad++; $display("FAIL init_resp got data=%h type=%0d len=%0d want 0/2/2", cache2mem_respstream_msg.data, cache2mem_respstream_msg.msg_type, cache2mem_respstream_msg.len); end
        n_cmp++; if (beat_log.size() != 1) begin n_bad++; $display("FAIL init_beat_count got %0d want 1", beat_log.size()); end
        else begin
            n_cmp++; if (beat_log[0].len !== 2'd2 || beat_log[0].data !== 32'h12345678 || beat_log[0].addr !== 32'h00000208) begin n_bad++; $display("FAIL init_beat got len=%0d data=%h addr=%h want 2/12345678/00000208", beat_log[0].len, beat_log[0].data, beat_log[0].addr); end
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        mem_req_4B_t   prev_req;
        mem_resp_16B_t prev_resp;
        mem_resp_16B_t got;
        logic          held_req;
        logic          held_resp;
        logic          done;
        held_req = 1'b0; held_resp = 1'b0; done = 1'b0; got = '0;
        prev_req = '0; prev_resp = '0;
        beat_log.delete();
        rd_words = '{32'h0A0A0A0A, 32'h1B1B1B1B, 32'h2C2C2C2C, 32'h3D3D3D3D};
        send_req(mk_req(MEM_TYPE_READ, 8'h77, 32'h00003000, 4'd0, 128'h0));
        for (int c = 0; c < 400 && !done; c++) begin
            if (held_req) begin
                n_cmp++; if (mem_reqstream_val !== 1'b1 || mem_reqstream_msg !== prev_req) begin n_bad++; $display("FAIL stall_req_stable got %h want %h", mem_reqstream_msg, prev_req); end
            end
            if (held_resp) begin
                n_cmp++; if (cache2mem_respstream_val !== 1'b1 || cache2mem_respstream_msg !== prev_resp) begin n_bad++; $display("FAIL stall_resp_stable got %h want %h", cache2mem_respstream_msg, prev_resp); end
            end
            mem_reqstream_rdy        = 1'($urandom_range(0, 1));
            cache2mem_respstream_rdy = 1'($urandom_range(0, 1));
            held_req  = mem_reqstream_val && !mem_reqstream_rdy;
            prev_req  = mem_reqstream_msg;
            held_resp = cache2mem_respstream_val && !cache2mem_respstream_rdy;
            prev_resp = cache2mem_respstream_msg;
            if (cache2mem_respstream_val && cache2mem_respstream_rdy) begin
                done = 1'b1;
                got  = cache2mem_respstream_msg;
            end
            @(negedge clk);
        end
        mem_reqstream_rdy        = 1'b1;
        cache2mem_respstream_rdy = 1'b1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_timeout got done=%b want 1", done); end
        n_cmp++; if (got.data !== 128'h3D3D3D3D_2C2C2C2C_1B1B1B1B_0A0A0A0A || got.opaque !== 8'h77) begin n_bad++; $display("FAIL stall_data got %h op=%h want 3d3d3d3d2c2c2c2c1b1b1b1b0a0a0a0a/77", got.data, got.opaque); end
        n_cmp++; if (beat_log.size() != 4) begin n_bad++; $display("FAIL stall_beat_count got %0d want 4", beat_log.size()); end
        for (int k = 0; k < 4 && k < beat_log.size(); k++) begin
            n_cmp++; if (beat_log[k].addr !== 32'h00003000 + 32'(4 * k)) begin n_bad++; $display("FAIL stall_beat%0d got addr=%h want %h", k, beat_log[k].addr, 32'h00003000 + 32'(4 * k)); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        beat_log.delete();
        rd_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        cache2mem_reqstream_msg = mk_req(MEM_TYPE_READ, 8'hA1, 32'h00004000, 4'd0, 128'h0);
        cache2mem_reqstream_val = 1'b1;
        @(negedge clk);
        cache2mem_reqstream_msg = mk_req(MEM_TYPE_READ, 8'hB2, 32'h00004010, 4'd0, 128'h0);
        n_cmp++; if (cache2mem_reqstream_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_blocking got rdy=%b want 0", cache2mem_reqstream_rdy); end
        wait_resp(20, lat);
        n_cmp++; if (cache2mem_respstream_val !== 1'b1 || lat != 6 || cache2mem_respstream_msg.opaque !== 8'hA1) begin n_bad++; $display("FAIL b2b_first got val=%b lat=%0d op=%h want 1/6/a1", cache2mem_respstream_val, lat, cache2mem_respstream_msg.opaque); end
        n_cmp++; if (cache2mem_reqstream_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_blocking_resp got rdy=%b want 0", cache2mem_reqstream_rdy); end
        @(negedge clk);
        n_cmp++; if (cache2mem_reqstream_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept got rdy=%b want 1", cache2mem_reqstream_rdy); end
        @(negedge clk);
        cache2mem_reqstream_val = 1'b0;
        cache2mem_reqstream_msg = '0;
        wait_resp(20, lat);
        n_cmp++; if (cache2mem_respstream_val !== 1'b1 || lat != 6 || cache2mem_respstream_msg.opaque !== 8'hB2) begin n_bad++; $display("FAIL b2b_second got val=%b lat=%0d op=%h want 1/6/b2", cache2mem_respstream_val, lat, cache2mem_respstream_msg.opaque); end
        n_cmp++; if (cache2mem_respstream_msg.data !== 128'h44444444_33333333_22222222_11111111) begin n_bad++; $display("FAIL b2b_data got %h want 44444444333333332222222211111111", cache2mem_respstream_msg.data); end
        n_cmp++; if (beat_log.size() != 8) begin n_bad++; $display("FAIL b2b_beat_count got %0d want 8", beat_log.size()); end
        else begin
            n_cmp++; if (beat_log[4].addr !== 32'h00004010 || beat_log[7].addr !== 32'h0000401C) begin n_bad++; $display("FAIL b2b_second_addrs got %h..%h want 00004010..0000401c", beat_log[4].addr, beat_log[7].addr); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        beat_log.delete();
        rd_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send_req(mk_req(MEM_TYPE_READ, 8'h44, 32'h00005000, 4'd0, 128'h0));
        repeat (3) @(negedge clk);
        n_cmp++; if (beat_log.size() != 3) begin n_bad++; $display("FAIL rm_beats_before got %0d want 3", beat_log.size()); end
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_reqstream_val !== 1'b0 || mem_reqstream_msg !== '0) begin n_bad++; $display("FAIL rm_req_cleared got val=%b msg=%h want 0/0", mem_reqstream_val, mem_reqstream_msg); end
        n_cmp++; if (mem_respstream_rdy !== 1'b0 || cache2mem_respstream_val !== 1'b0 || cache2mem_reqstream_rdy !== 1'b1) begin n_bad++; $display("FAIL rm_ctrl got mrdy=%b rval=%b crdy=%b want 0/0/1", mem_respstream_rdy, cache2mem_respstream_val, cache2mem_reqstream_rdy); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        beat_log.delete();
        send_req(mk_req(MEM_TYPE_READ, 8'h66, 32'h00006000, 4'd0, 128'h0));
        wait_resp(20, lat);
        n_cmp++; if (cache2mem_respstream_val !== 1'b1 || lat != 6 || cache2mem_respstream_msg.opaque !== 8'h66) begin n_bad++; $display("FAIL rm_next_resp got val=%b lat=%0d op=%h want 1/6/66", cache2mem_respstream_val, lat, cache2mem_respstream_msg.opaque); end
        n_cmp++; if (cache2mem_respstream_msg.data !== 128'h44444444_33333333_22222222_11111111) begin n_bad++; $display("FAIL rm_next_data got %h want 44444444333333332222222211111111", cache2mem_respstream_msg.data); end
        n_cmp++; if (beat_log.size() != 4) begin n_bad++; $display("FAIL rm_next_beats got %0d want 4", beat_log.size()); end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                    = 1'b0;
        cache2mem_reqstream_msg  = '0;
        cache2mem_reqstream_val  = 1'b0;
        cache2mem_respstream_rdy = 1'b1;
        mem_reqstream_rdy        = 1'b1;
        rd_words                 = '{32'h0, 32'h0, 32'h0, 32'h0};
        test_reset();
        test_full_read();
        test_single_word();
        test_full_write();
        test_init_word();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
